input4_debounce: RTL and testbench

Four-channel switch conditioner that sits directly upstream of the four-input AOI gate logic. It synchronizes raw board switches `sw_in[3:0]` into the clock domain and filters contact bounce on each channel. It presents clean levels `sw_db[3:0]`, which drive the gate's `a`, `b`, `c`, `d` inputs in that bit order. It also produces one-cycle rise/fall pulses per channel for downstream counters or LEDs.

---
 rtl/input4_pkg.sv | 19 +
 rtl/debounce_bit.sv | 96 +++++++++
 rtl/input4_debounce.sv | 39 +++
 tb/tb_input4_debounce.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/input4_pkg.sv
// Shared definitions for the four-channel switch debouncer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input4_pkg;

   // Per-channel FSM encoding: STABLE means synchronized input equals output level.
   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_SETTLE = 1'b1
   } db_state_t;

   // 1 ms qualification at 100 MHz; counter wide enough to hold DB_CYCLES-1.
   localparam int DB_CYCLES_DEF = 100000;
   localparam int CNT_W_DEF     = 17;

   // Channel count: bits map to the AOI gate inputs a, b, c, d.
   localparam int NCH = 4;

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: 2-FF synchronizer, stability FSM/counter, rise/fall pulses.
// Latency: sw_db follows a stable sw_in change DB_CYCLES+2 edges after the input changes.
// Backpressure: none; free-running, pulses are single-cycle and not held.
module debounce_bit
   import input4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic sw_in,
   output logic sw_db,
   output logic sw_rise,
   output logic sw_fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic             s1;
   logic             s;
   db_state_t        state;
   db_state_t        state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             db_nxt;
   logic             rise_nxt;
   logic             fall_nxt;

   // Two-flop synchronizer bringing the raw switch level into the clock domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s  <= 1'b0;
      end else begin
         s1 <= sw_in;
         s  <= s1;
      end
   end

   // Qualify a level change: it must persist for DB_CYCLES consecutive samples.
   // Any sample matching the current output discards the attempt; the counter
   // saturates at CNT_LAST by construction since that value always ends SETTLE.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      db_nxt    = sw_db;
      rise_nxt  = 1'b0;
      fall_nxt  = 1'b0;
      case (state)
         ST_STABLE: begin
            if (s != sw_db) begin
               state_nxt = ST_SETTLE;
               cnt_nxt   = CNT_ONE;
            end
         end
         ST_SETTLE: begin
            if (s == sw_db) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = ST_STABLE;
               cnt_nxt   = '0;
               db_nxt    = s;
               rise_nxt  = s;
               fall_nxt  = ~s;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = ST_STABLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State, counter, clean level and edge pulses are all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_STABLE;
         cnt     <= '0;
         sw_db   <= 1'b0;
         sw_rise <= 1'b0;
         sw_fall <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         sw_db   <= db_nxt;
         sw_rise <= rise_nxt;
         sw_fall <= fall_nxt;
      end
   end

endmodule

// File: rtl/input4_debounce.sv
// Four independent switch debouncers feeding the AOI gate inputs a..d (bit 0..3).
// Latency: DB_CYCLES+2 edges from a stable sw_in change to sw_db / pulse update.
// Backpressure: none; outputs are registered levels and single-cycle pulses.
module input4_debounce
   import input4_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic [NCH-1:0] sw_in,
   output logic [NCH-1:0] sw_db,
   output logic [NCH-1:0] sw_rise,
   output logic [NCH-1:0] sw_fall
);

   // The counter must be able to reach DB_CYCLES-1 without wrapping.
   if (DB_CYCLES < 2 || DB_CYCLES > (2 ** CNT_W) - 1) begin : g_param_bad
      $error("input4_debounce: DB_CYCLES=%0d outside 2..2^CNT_W-1 (CNT_W=%0d)",
             DB_CYCLES, CNT_W);
   end

   // One fully independent channel per switch.
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      debounce_bit #(
         .DB_CYCLES (DB_CYCLES),
         .CNT_W     (CNT_W)
      ) u_bit (
         .clk     (clk),
         .rst_n   (rst_n),
         .sw_in   (sw_in[i]),
         .sw_db   (sw_db[i]),
         .sw_rise (sw_rise[i]),
         .sw_fall (sw_fall[i])
      );
   end

endmodule

// File: tb/tb_input4_debounce.sv
// Directed bench for input4_debounce with DB_CYCLES=4, CNT_W=3.
// Expected outputs are queued per edge from the documented timing and popped after each edge.
// Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
module tb_input4_debounce;

   logic       clk;
   logic       rst_n;
   logic [3:0] sw_in;
   logic [3:0] sw_db;
   logic [3:0] sw_rise;
   logic [3:0] sw_fall;

   typedef struct {
      logic [3:0] db;
      logic [3:0] rise;
      logic [3:0] fall;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   n_asserts;
   int   n_fails;

   input4_debounce #(
      .DB_CYCLES (4),
      .CNT_W     (3)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .sw_db   (sw_db),
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Queue n identical expected output samples.
   task automatic push(input int n, input logic [3:0] db, input logic [3:0] rise,
                       input logic [3:0] fall, input string tag);
      exp_t e;
      e.db   = db;
      e.rise = rise;
      e.fall = fall;
      e.tag  = tag;
      for (int k = 0; k < n; k++) sb.push_back(e);
   endtask

   // Pop one expected sample and compare all three outputs.
   task automatic check_pop();
      exp_t e;
      n_asserts++;
      assert (sb.size() != 0) else begin
         n_fails++;
         $error("FAIL scoreboard_empty: got no expected entry, required one");
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         n_asserts++;
         assert (sw_db === e.db) else begin
            n_fails++;
            $error("FAIL %s sw_db: got %h required %h", e.tag, sw_db, e.db);
         end
         n_asserts++;
         assert (sw_rise === e.rise) else begin
            n_fails++;
            $error("FAIL %s sw_rise: got %h required %h", e.tag, sw_rise, e.rise);
         end
         n_asserts++;
         assert (sw_fall === e.fall) else begin
            n_fails++;
            $error("FAIL %s sw_fall: got %h required %h", e.tag, sw_fall, e.fall);
         end
      end
   endtask

   // Drive sw_in, take one rising edge, then check the output sample.
   task automatic step(input logic [3:0] sw);
      sw_in = sw;
      @(posedge clk);
      #1;
      check_pop();
   endtask

   initial begin
      logic [8:0] bounce;
      n_asserts = 0;
      n_fails   = 0;
      bounce    = 9'b1_1110_1101;   // bit k = sample k: 1,0,1,1,0,1,1,1,1
      rst_n     = 1'b0;
      sw_in     = 4'hF;

      // Reset held with all switches high: everything stays 0.
      push(2, 4'h0, 4'h0, 4'h0, "reset_hold");
      step(4'hF);
      step(4'hF);

      // Release: edge 1 captures F, sw_db rises at edge 6 with one rise pulse.
      rst_n = 1'b1;
      push(5, 4'h0, 4'h0, 4'h0, "rel_wait");
      push(1, 4'hF, 4'hF, 4'h0, "rel_rise");
      push(3, 4'hF, 4'h0, 4'h0, "rel_hold");
      repeat (9) step(4'hF);

      // Simultaneous release of all four channels.
      push(5, 4'hF, 4'h0, 4'h0, "fall_wait");
      push(1, 4'h0, 4'h0, 4'hF, "fall_edge");
      push(3, 4'h0, 4'h0, 4'h0, "fall_hold");
      repeat (9) step(4'h0);

      // Clean press on bit 0.
      push(5, 4'h0, 4'h0, 4'h0, "press_wait");
      push(1, 4'h1, 4'h1, 4'h0, "press_rise");
      push(3, 4'h1, 4'h0, 4'h0, "press_hold");
      repeat (9) step(4'h1);

      // Bounce on bit 2: accepted only after the final run of four ones (edge 11).
      push(10, 4'h1, 4'h0, 4'h0, "bounce_wait");
      push(1,  4'h5, 4'h4, 4'h0, "bounce_rise");
      push(3,  4'h5, 4'h0, 4'h0, "bounce_hold");
      for (int k = 0; k < 14; k++) begin
         if (k < 9) step(bounce[k] ? 4'h5 : 4'h1);
         else       step(4'h5);
      end

      // Glitch: three samples high on bit 3 fall one short of acceptance.
      push(12, 4'h5, 4'h0, 4'h0, "glitch");
      repeat (3) step(4'hD);
      repeat (9) step(4'h5);

      // Reset mid-settle on bit 1 after the counter reaches 2.
      push(4, 4'h5, 4'h0, 4'h0, "mid_count");
      repeat (4) step(4'h7);
      rst_n = 1'b0;
      #1;
      push(1, 4'h0, 4'h0, 4'h0, "mid_async");
      check_pop();
      push(2, 4'h0, 4'h0, 4'h0, "mid_hold");
      repeat (2) step(4'h7);
      #1;
      rst_n = 1'b1;
      push(5, 4'h0, 4'h0, 4'h0, "requal_wait");
      push(1, 4'h7, 4'h7, 4'h0, "requal_rise");
      push(3, 4'h7, 4'h0, 4'h0, "requal_hold");
      repeat (9) step(4'h7);

      n_asserts++;
      assert (sb.size() == 0) else begin
         n_fails++;
         $error("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
      $finish;
   end

endmodule
